imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 188 ++++++++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a serial byte stream into big-endian words and writes them into instruction memory.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int bit_size = 32,
  parameter int mem_size = 16,
  parameter int WORDS    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [mem_size-1:0] load_len,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                IM_wr_en,
  output logic [mem_size-1:0] IM_wr_Address,
  output logic [bit_size-1:0] IM_wr_Data,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic                err
);

  // state | meaning
  // IDLE  | waiting for start; cpu_rst reflects the last session outcome
  // RECV  | accepting bytes of the current word
  // WRITE | one-cycle instruction-memory write strobe
  // CHK   | accepting the checksum byte (checksum build only)
  // DONE  | one-cycle completion pulse, then back to IDLE
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

  localparam int BYTES = bit_size / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0]       LAST_BYTE = CW'(BYTES - 1);
  localparam logic [mem_size-1:0] WORDS_L   = mem_size'(WORDS);

  state_t              state_q, state_d;
  logic [mem_size-1:0] len_q, len_d;
  logic [mem_size-1:0] idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [bit_size-9:0] acc_q, acc_d;
  logic [mem_size-1:0] addr_q, addr_d;
  logic [bit_size-1:0] data_q, data_d;
  logic                err_q, err_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic                byte_fire;
  logic [bit_size-1:0] word_next;
  logic [mem_size-1:0] idx_inc;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == RECV) || (state_q == CHK);
`else
  assign byte_ready = (state_q == RECV);
`endif
  assign byte_fire = byte_valid && byte_ready;
  assign word_next = {acc_q, byte_data};
  assign idx_inc   = idx_q + mem_size'(1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (load_len == '0 || load_len > WORDS_L) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            len_d     = load_len;
            idx_d     = '0;
            cnt_d     = '0;
            err_d     = 1'b0;
            cpu_rst_d = 1'b1;
            state_d   = RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d     = '0;
`endif
          end
        end
      end
      RECV: begin
        if (byte_fire) begin
          acc_d = word_next[bit_size-9:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + byte_data;
`endif
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            addr_d  = idx_q;
            data_d  = word_next;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WRITE: begin
        // The index is held on the final word so it never reaches WORDS.
        if (idx_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end else begin
          idx_d   = idx_inc;
          state_d = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (byte_fire) begin
          if (byte_data != sum_q) err_d = 1'b1;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        if (!err_q) cpu_rst_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign IM_wr_en      = (state_q == WRITE);
  assign IM_wr_Address = addr_q;
  assign IM_wr_Data    = data_q;
  assign cpu_rst       = cpu_rst_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; expected writes/done events are queued at stimulus time
// and consumed by an independent monitor. Honours IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;
  localparam int BW    = 32;
  localparam int MW    = 16;
  localparam int WORDS = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [MW-1:0] load_len = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready, IM_wr_en, cpu_rst, busy, done, err;
  logic [MW-1:0] IM_wr_Address;
  logic [BW-1:0] IM_wr_Data;

  imem_loader #(.bit_size(BW), .mem_size(MW), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .IM_wr_en(IM_wr_en), .IM_wr_Address(IM_wr_Address), .IM_wr_Data(IM_wr_Data),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [MW-1:0] addr; logic [BW-1:0] data; } wr_t;
  wr_t  exp_wr_q[$];
  logic exp_done_q[$];
  int   tests = 0;
  int   fails = 0;
  int   wr_seen = 0;

  logic [7:0] basic[$] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h04};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      if (IM_wr_en) begin
        wr_t e;
        wr_seen++;
        if (exp_wr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wr_unexpected: write addr %0h data %0h, none expected", IM_wr_Address, IM_wr_Data);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_addr", 64'(IM_wr_Address), 64'(e.addr));
          check("wr_data", 64'(IM_wr_Data), 64'(e.data));
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexpected: done pulse with err %0b, none expected", err);
        end else begin
          check("done_err", 64'(err), 64'(exp_done_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [MW-1:0] len);
    start = 1'b1;
    load_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      tests++;
      fails++;
      $display("FAIL byte_ready_timeout: byte_ready 0 after %0d cycles, required 1", n);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy 1 after %0d cycles, required 0", n);
    end
  endtask

  function automatic logic [7:0] byte_sum(input logic [7:0] bytes[$]);
    logic [7:0] s = '0;
    foreach (bytes[i]) s = s + bytes[i];
    return s;
  endfunction

  task automatic push_words(input logic [7:0] bytes[$], input int first, input int last);
    for (int i = first; i <= last; i++) begin
      wr_t w;
      w.addr = MW'(i);
      w.data = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
      exp_wr_q.push_back(w);
    end
  endtask

  task automatic run_load(input logic [7:0] bytes[$], input int len, input int gap_lo,
                          input int gap_hi, input bit bad_ck, input bit mid_start);
    logic exp_err;
    logic [7:0] ck;
    exp_err = CK_EN && bad_ck;
    ck = byte_sum(bytes) + (bad_ck ? 8'd1 : 8'd0);
    push_words(bytes, 0, len - 1);
    exp_done_q.push_back(exp_err);
    pulse_start(MW'(len));
    foreach (bytes[i]) begin
      send_byte(bytes[i], int'($urandom_range(gap_hi, gap_lo)));
      if (mid_start && i == 1) pulse_start(MW'(5));
    end
    if (CK_EN) send_byte(ck, 0);
    wait_idle();
    tick(1);
    check("err_after_load", 64'(err), 64'(exp_err));
    check("cpu_rst_after_load", 64'(cpu_rst), 64'(exp_err));
    check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    check("done_queue_drained", 64'(exp_done_q.size()), 64'd0);
  endtask

  task automatic bad_len(input logic [MW-1:0] len);
    int w0 = wr_seen;
    exp_done_q.push_back(1'b1);
    pulse_start(len);
    tick(2);
    check("badlen_err", 64'(err), 64'd1);
    check("badlen_cpu_rst", 64'(cpu_rst), 64'd1);
    check("badlen_busy", 64'(busy), 64'd0);
    check("badlen_done_seen", 64'(exp_done_q.size()), 64'd0);
    check("badlen_no_write", 64'(wr_seen - w0), 64'd0);
  endtask

  initial begin
    int w0;
    logic [7:0] rnd[$];
    int len;

    rst = 1'b0;
    tick(3);
    check("rst_wr_en", 64'(IM_wr_en), 64'd0);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_addr", 64'(IM_wr_Address), 64'd0);
    check("rst_data", 64'(IM_wr_Data), 64'd0);
    rst = 1'b1;
    tick(2);

    bad_len(MW'(0));
    bad_len(MW'(WORDS + 1));

    run_load(basic, 2, 0, 0, 1'b0, 1'b0);

    w0 = wr_seen;
    run_load(basic, 2, 3, 3, 1'b0, 1'b0);
    check("stall_write_count", 64'(wr_seen - w0), 64'd2);

    // Abort after five bytes: only word 0 may be written.
    w0 = wr_seen;
    push_words(basic, 0, 0);
    pulse_start(MW'(2));
    for (int i = 0; i < 5; i++) send_byte(basic[i], 0);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(5);
    check("abort_write_count", 64'(wr_seen - w0), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cpu_rst", 64'(cpu_rst), 64'd1);
    check("abort_addr", 64'(IM_wr_Address), 64'd0);
    check("abort_data", 64'(IM_wr_Data), 64'd0);
    check("abort_wr_drained", 64'(exp_wr_q.size()), 64'd0);
    run_load(basic, 2, 0, 1, 1'b0, 1'b0);

    run_load(basic, 2, 0, 0, 1'b0, 1'b1);

    run_load(basic, 2, 0, 0, 1'b1, 1'b0);
    run_load(basic, 2, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      len = int'($urandom_range(6, 1));
      rnd.delete();
      for (int b = 0; b < 4 * len; b++) rnd.push_back(8'($urandom_range(255, 0)));
      run_load(rnd, len, 0, 2, 1'($urandom_range(1, 0)), 1'b0);
    end

    rnd.delete();
    for (int b = 0; b < 4 * WORDS; b++) rnd.push_back(8'($urandom_range(255, 0)));
    run_load(rnd, WORDS, 0, 0, 1'b0, 1'b0);
    check("max_len_last_addr", 64'(IM_wr_Address), 64'(WORDS - 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
